chaos_iter_ctrl: RTL

CHAOS_ITER_CTRL -- requirements
Module: chaos_iter_ctrl

---
 rtl/chaos_pkg.sv | 15 +
 rtl/chaos_wdt.sv | 36 +++
 rtl/chaos_iter_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/chaos_pkg.sv
// Shared definitions for the chaotic-system iteration controller.
// Holds the controller state encoding and default word/counter widths.
package chaos_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int CNT_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } chaos_state_e;

endpackage

// File: rtl/chaos_wdt.sv
// Watchdog for one WAIT phase: counts enabled cycles from a clear and flags
// expiry on the TIMEOUT_CYCLES-th one. Only built with CHAOS_CTRL_TIMEOUT_EN.
module chaos_wdt #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chaos_iter_ctrl.sv
// Iteration controller feeding x/y/z equation pipelines and collecting results.
// Define CHAOS_CTRL_TIMEOUT_EN to add the per-iteration WAIT watchdog.
module chaos_iter_ctrl
    import chaos_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  iter_count,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] z0,
    output logic                  xn_valid,
    output logic                  yn_valid,
    output logic                  zn_valid,
    output logic [DATA_WIDTH-1:0] xn,
    output logic [DATA_WIDTH-1:0] yn,
    output logic [DATA_WIDTH-1:0] zn,
    input  logic                  xn1_valid,
    input  logic                  yn1_valid,
    input  logic                  zn1_valid,
    input  logic [DATA_WIDTH-1:0] xn1,
    input  logic [DATA_WIDTH-1:0] yn1,
    input  logic [DATA_WIDTH-1:0] zn1,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_z,
    output logic [CNT_WIDTH-1:0]  out_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    chaos_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [DATA_WIDTH-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d, cap_z_q, cap_z_d;
    logic [DATA_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic [DATA_WIDTH-1:0] nxt_x, nxt_y, nxt_z;
    logic                  got_x_q, got_x_d, got_y_q, got_y_d, got_z_q, got_z_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, iter_q, iter_d, out_idx_q, out_idx_d;
    logic                  out_valid_q, out_valid_d, done_q, done_d;
    logic [CNT_WIDTH:0]    cnt_inc;
    logic                  all_cap, last_iter, wdt_expire;

    // A channel arriving in the same cycle as the others still completes the set.
    assign nxt_x   = got_x_q ? cap_x_q : xn1;
    assign nxt_y   = got_y_q ? cap_y_q : yn1;
    assign nxt_z   = got_z_q ? cap_z_q : zn1;
    assign all_cap = (got_x_q | xn1_valid) & (got_y_q | yn1_valid) & (got_z_q | zn1_valid);

    // One extra bit keeps counter+1 from wrapping when iter_count is all ones.
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
    assign last_iter = (cnt_inc >= {1'b0, iter_q});

`ifdef CHAOS_CTRL_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;

    chaos_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != WAIT),
        .enable(state_q == WAIT),
        .expire(wdt_expire)
    );

    always_comb begin
        timeout_err_d = timeout_err_q;
        if (state_q == IDLE && start) begin
            timeout_err_d = 1'b0;
        end else if (state_q == WAIT && !abort && !all_cap && wdt_expire) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign wdt_expire            = 1'b0;
    assign timeout_err           = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && iter_count != '0) state_d = ISSUE;
            ISSUE:   state_d = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)           state_d = IDLE;
                else if (all_cap)    state_d = last_iter ? FINISH : ISSUE;
                else if (wdt_expire) state_d = IDLE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        xn_valid = (state_q == ISSUE);
        yn_valid = (state_q == ISSUE);
        zn_valid = (state_q == ISSUE);
    end

    always_comb begin
        x_d = x_q;         y_d = y_q;         z_d = z_q;
        cap_x_d = cap_x_q; cap_y_d = cap_y_q; cap_z_d = cap_z_q;
        got_x_d = got_x_q; got_y_d = got_y_q; got_z_d = got_z_q;
        out_x_d = out_x_q; out_y_d = out_y_q; out_z_d = out_z_q;
        cnt_d       = cnt_q;
        iter_d      = iter_q;
        out_idx_d   = out_idx_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && iter_count != '0) begin
                    x_d = x0; y_d = y0; z_d = z0;
                    got_x_d = 1'b0; got_y_d = 1'b0; got_z_d = 1'b0;
                    cnt_d  = '0;
                    iter_d = iter_count;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            ISSUE: begin
                if (abort) begin
                    got_x_d = 1'b0; got_y_d = 1'b0; got_z_d = 1'b0;
                end
            end
            WAIT: begin
                if (abort || (!all_cap && wdt_expire)) begin
                    got_x_d = 1'b0; got_y_d = 1'b0; got_z_d = 1'b0;
                end else if (all_cap) begin
                    out_valid_d = 1'b1;
                    out_x_d = nxt_x; out_y_d = nxt_y; out_z_d = nxt_z;
                    x_d     = nxt_x; y_d     = nxt_y; z_d     = nxt_z;
                    got_x_d = 1'b0;  got_y_d = 1'b0;  got_z_d = 1'b0;
                    out_idx_d = cnt_q;
                    cnt_d     = cnt_inc[CNT_WIDTH-1:0];
                end else begin
                    if (xn1_valid && !got_x_q) begin cap_x_d = xn1; got_x_d = 1'b1; end
                    if (yn1_valid && !got_y_q) begin cap_y_d = yn1; got_y_d = 1'b1; end
                    if (zn1_valid && !got_z_q) begin cap_z_d = zn1; got_z_d = 1'b1; end
                end
            end
            FINISH:  done_d = !abort;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;         y_q <= '0;         z_q <= '0;
            cap_x_q <= '0;     cap_y_q <= '0;     cap_z_q <= '0;
            got_x_q <= 1'b0;   got_y_q <= 1'b0;   got_z_q <= 1'b0;
            out_x_q <= '0;     out_y_q <= '0;     out_z_q <= '0;
            cnt_q       <= '0;
            iter_q      <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            x_q <= x_d;         y_q <= y_d;         z_q <= z_d;
            cap_x_q <= cap_x_d; cap_y_q <= cap_y_d; cap_z_q <= cap_z_d;
            got_x_q <= got_x_d; got_y_q <= got_y_d; got_z_q <= got_z_d;
            out_x_q <= out_x_d; out_y_q <= out_y_d; out_z_q <= out_z_d;
            cnt_q       <= cnt_d;
            iter_q      <= iter_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign xn        = x_q;
    assign yn        = y_q;
    assign zn        = z_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;

endmodule
